// File: rtl/complex_issue_queue_pkg.sv
// ============================================================================
//  Module      : complex_issue_queue_pkg
//  Description : Shared widths, op-type encodings and the issue-queue entry
//                layout for the complex (div/mod) pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package complex_issue_queue_pkg;

    localparam int PREG_INDEX_WIDTH      = 6;
    localparam int ROB_ENTRY_INDEX_WIDTH = 5;

    // General op type of every three-register ALU-class micro-op.
    localparam logic [3:0] GENERAL_OPTYPE_3R = 4'd1;

    // Specific op types handled by the complex pipe.
    localparam logic [4:0] _3R_DIV  = 5'd16;
    localparam logic [4:0] _3R_MOD  = 5'd17;
    localparam logic [4:0] _3R_DIVU = 5'd18;
    localparam logic [4:0] _3R_MODU = 5'd19;

    localparam int COMPLEX_IQ_DEPTH = 4;

    typedef struct packed {
        logic                             valid;
        logic [3:0]                       gen_op_type;
        logic [4:0]                       spec_op_type;
        logic [ROB_ENTRY_INDEX_WIDTH-1:0] rob;
        logic [PREG_INDEX_WIDTH-1:0]      rd;
        logic [PREG_INDEX_WIDTH-1:0]      rj;
        logic [PREG_INDEX_WIDTH-1:0]      rk;
        logic                             rj_rdy;
        logic                             rk_rdy;
    } complex_iq_entry_t;

endpackage

`default_nettype wire

// File: rtl/complex_issue_queue_wakeup_match.sv
// ============================================================================
//  Module      : iq_wakeup_match
//  Description : Compares one source tag against every wakeup broadcast port
//                and flags a hit on any valid port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iq_wakeup_match
    import complex_issue_queue_pkg::*;
#(
    parameter int WAKE_PORTS = 2
) (
    input  logic [PREG_INDEX_WIDTH-1:0]            tag_i,
    input  logic [WAKE_PORTS-1:0]                  wake_valid_i,
    input  logic [WAKE_PORTS*PREG_INDEX_WIDTH-1:0] wake_preg_index_i,
    output logic                                   match_o
);

    logic [WAKE_PORTS-1:0] hit_w;

    genvar p;
    generate
        for (p = 0; p < WAKE_PORTS; p++) begin : g_port
            // A port hits only when its strobe is up and its tag equals ours.
            assign hit_w[p] = wake_valid_i[p] &&
                (wake_preg_index_i[p*PREG_INDEX_WIDTH +: PREG_INDEX_WIDTH] == tag_i);
        end
    endgenerate

    assign match_o = |hit_w;

endmodule

`default_nettype wire

// File: rtl/complex_issue_queue.sv
// ============================================================================
//  Module      : complex_issue_queue
//  Description : Age-ordered compacting issue queue for the div/mod pipe.
//                Tracks operand readiness through wakeup broadcasts and
//                presents the oldest fully-ready entry to register read.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module complex_issue_queue
    import complex_issue_queue_pkg::*;
#(
    parameter int DEPTH      = COMPLEX_IQ_DEPTH,
    parameter int WAKE_PORTS = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   enq_valid,
    output logic                                   enq_ready,
    input  logic [3:0]                             enq_gen_op_type,
    input  logic [4:0]                             enq_spec_op_type,
    input  logic [ROB_ENTRY_INDEX_WIDTH-1:0]       enq_rob_entry_index,
    input  logic [PREG_INDEX_WIDTH-1:0]            enq_preg_rd_index,
    input  logic [PREG_INDEX_WIDTH-1:0]            enq_preg_rj_index,
    input  logic [PREG_INDEX_WIDTH-1:0]            enq_preg_rk_index,
    input  logic                                   enq_rj_ready,
    input  logic                                   enq_rk_ready,
    input  logic [WAKE_PORTS-1:0]                  wake_valid,
    input  logic [WAKE_PORTS*PREG_INDEX_WIDTH-1:0] wake_preg_index,
    input  logic                                   flush,
    input  logic                                   FU_ready,
    output logic                                   IQ_valid,
    output logic [3:0]                             iss_gen_op_type,
    output logic [4:0]                             iss_spec_op_type,
    output logic [ROB_ENTRY_INDEX_WIDTH-1:0]       rob_entry_index,
    output logic [PREG_INDEX_WIDTH-1:0]            preg_rd_index,
    output logic [PREG_INDEX_WIDTH-1:0]            preg_rj_index,
    output logic [PREG_INDEX_WIDTH-1:0]            preg_rk_index,
    output logic [$clog2(DEPTH+1)-1:0]             entry_count
);

    localparam int CW = $clog2(DEPTH+1);

    complex_iq_entry_t [DEPTH-1:0] entries_q;
    complex_iq_entry_t [DEPTH-1:0] entries_d;
    logic [CW-1:0]                 count_q;
    logic [CW-1:0]                 count_d;

    complex_iq_entry_t [DEPTH-1:0] upd_w;        // slots with this cycle's wakeups applied
    complex_iq_entry_t [DEPTH-1:0] shift_src_w;  // what each slot receives on a shift
    complex_iq_entry_t             new_entry_w;
    logic [DEPTH-1:0]              match_j_w;
    logic [DEPTH-1:0]              match_k_w;
    logic                          enq_match_j_w;
    logic                          enq_match_k_w;
    logic [DEPTH-1:0]              sel_rdy_w;
    logic [DEPTH-1:0]              shift_mask_w; // slot index >= selected slot
    logic                          enq_fire_w;
    logic                          issue_fire_w;
    logic [CW-1:0]                 wr_idx_w;

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_slot
            iq_wakeup_match #(.WAKE_PORTS(WAKE_PORTS)) u_match_j (
                .tag_i             (entries_q[i].rj),
                .wake_valid_i      (wake_valid),
                .wake_preg_index_i (wake_preg_index),
                .match_o           (match_j_w[i])
            );
            iq_wakeup_match #(.WAKE_PORTS(WAKE_PORTS)) u_match_k (
                .tag_i             (entries_q[i].rk),
                .wake_valid_i      (wake_valid),
                .wake_preg_index_i (wake_preg_index),
                .match_o           (match_k_w[i])
            );
            // Candidate status uses registered ready bits only, so a wakeup
            // becomes visible to select one cycle later.
            assign sel_rdy_w[i] = entries_q[i].valid && entries_q[i].rj_rdy &&
                                  entries_q[i].rk_rdy;
        end
    endgenerate

    generate
        begin : g_enq_match
            iq_wakeup_match #(.WAKE_PORTS(WAKE_PORTS)) u_match_j (
                .tag_i             (enq_preg_rj_index),
                .wake_valid_i      (wake_valid),
                .wake_preg_index_i (wake_preg_index),
                .match_o           (enq_match_j_w)
            );
            iq_wakeup_match #(.WAKE_PORTS(WAKE_PORTS)) u_match_k (
                .tag_i             (enq_preg_rk_index),
                .wake_valid_i      (wake_valid),
                .wake_preg_index_i (wake_preg_index),
                .match_o           (enq_match_k_w)
            );
        end
    endgenerate

    assign enq_ready    = (count_q < CW'(DEPTH));
    assign IQ_valid     = |sel_rdy_w;
    assign enq_fire_w   = enq_valid && enq_ready && !flush;
    assign issue_fire_w = IQ_valid && FU_ready && !flush;
    assign wr_idx_w     = count_q - CW'(issue_fire_w);
    assign entry_count  = count_q;

    // Incoming entry, with same-cycle wakeups bypassed into its ready bits.
    always_comb begin
        new_entry_w              = '0;
        new_entry_w.valid        = 1'b1;
        new_entry_w.gen_op_type  = enq_gen_op_type;
        new_entry_w.spec_op_type = enq_spec_op_type;
        new_entry_w.rob          = enq_rob_entry_index;
        new_entry_w.rd           = enq_preg_rd_index;
        new_entry_w.rj           = enq_preg_rj_index;
        new_entry_w.rk           = enq_preg_rk_index;
        new_entry_w.rj_rdy       = enq_rj_ready | enq_match_j_w;
        new_entry_w.rk_rdy       = enq_rk_ready | enq_match_k_w;
    end

    // Apply wakeups to live slots and build the shift-down source vector.
    always_comb begin
        upd_w       = entries_q;
        shift_src_w = '0;
        for (int s = 0; s < DEPTH; s++) begin
            if (entries_q[s].valid) begin
                upd_w[s].rj_rdy = entries_q[s].rj_rdy | match_j_w[s];
                upd_w[s].rk_rdy = entries_q[s].rk_rdy | match_k_w[s];
            end
        end
        for (int s = 0; s < DEPTH-1; s++) begin
            shift_src_w[s] = upd_w[s+1];
        end
    end

    // Priority encoder: oldest ready slot drives the issue fields.
    always_comb begin
        logic found;
        found            = 1'b0;
        shift_mask_w     = '0;
        iss_gen_op_type  = '0;
        iss_spec_op_type = '0;
        rob_entry_index  = '0;
        preg_rd_index    = '0;
        preg_rj_index    = '0;
        preg_rk_index    = '0;
        for (int s = 0; s < DEPTH; s++) begin
            if (sel_rdy_w[s] && !found) begin
                iss_gen_op_type  = entries_q[s].gen_op_type;
                iss_spec_op_type = entries_q[s].spec_op_type;
                rob_entry_index  = entries_q[s].rob;
                preg_rd_index    = entries_q[s].rd;
                preg_rj_index    = entries_q[s].rj;
                preg_rk_index    = entries_q[s].rk;
            end
            found           = found | sel_rdy_w[s];
            shift_mask_w[s] = found;
        end
    end

    // Next queue contents: compact on issue, append on enqueue, flush clears.
    always_comb begin
        entries_d = upd_w;
        count_d   = count_q + CW'(enq_fire_w) - CW'(issue_fire_w);
        for (int s = 0; s < DEPTH; s++) begin
            if (issue_fire_w && shift_mask_w[s]) begin
                entries_d[s] = shift_src_w[s];
            end
            if (enq_fire_w && (wr_idx_w == CW'(s))) begin
                entries_d[s] = new_entry_w;
            end
        end
        if (flush) begin
            entries_d = '0;
            count_d   = '0;
        end
    end

    // State registers; reset discards every entry immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries_q <= '0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_complex_issue_queue.sv
// ============================================================================
//  Module      : tb_complex_issue_queue
//  Description : Directed self-checking bench for complex_issue_queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_complex_issue_queue;
    import complex_issue_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int WP    = 2;
    localparam int PW    = PREG_INDEX_WIDTH;
    localparam int RW    = ROB_ENTRY_INDEX_WIDTH;

    logic            clk = 1'b0;
    logic            rst;
    logic            enq_valid;
    logic            enq_ready;
    logic [3:0]      enq_gen_op_type;
    logic [4:0]      enq_spec_op_type;
    logic [RW-1:0]   enq_rob_entry_index;
    logic [PW-1:0]   enq_preg_rd_index;
    logic [PW-1:0]   enq_preg_rj_index;
    logic [PW-1:0]   enq_preg_rk_index;
    logic            enq_rj_ready;
    logic            enq_rk_ready;
    logic [WP-1:0]   wake_valid;
    logic [WP*PW-1:0] wake_preg_index;
    logic            flush;
    logic            FU_ready;
    logic            IQ_valid;
    logic [3:0]      iss_gen_op_type;
    logic [4:0]      iss_spec_op_type;
    logic [RW-1:0]   rob_entry_index;
    logic [PW-1:0]   preg_rd_index;
    logic [PW-1:0]   preg_rj_index;
    logic [PW-1:0]   preg_rk_index;
    logic [2:0]      entry_count;

    int vectors     = 0;
    int miscompares = 0;

    complex_issue_queue #(.DEPTH(DEPTH), .WAKE_PORTS(WP)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .enq_valid           (enq_valid),
        .enq_ready           (enq_ready),
        .enq_gen_op_type     (enq_gen_op_type),
        .enq_spec_op_type    (enq_spec_op_type),
        .enq_rob_entry_index (enq_rob_entry_index),
        .enq_preg_rd_index   (enq_preg_rd_index),
        .enq_preg_rj_index   (enq_preg_rj_index),
        .enq_preg_rk_index   (enq_preg_rk_index),
        .enq_rj_ready        (enq_rj_ready),
        .enq_rk_ready        (enq_rk_ready),
        .wake_valid          (wake_valid),
        .wake_preg_index     (wake_preg_index),
        .flush               (flush),
        .FU_ready            (FU_ready),
        .IQ_valid            (IQ_valid),
        .iss_gen_op_type     (iss_gen_op_type),
        .iss_spec_op_type    (iss_spec_op_type),
        .rob_entry_index     (rob_entry_index),
        .preg_rd_index       (preg_rd_index),
        .preg_rj_index       (preg_rj_index),
        .preg_rk_index       (preg_rk_index),
        .entry_count         (entry_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sampling and driving happen 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [4:0] spec, input logic [RW-1:0] rob,
                       input logic [PW-1:0] rd, input logic [PW-1:0] rj,
                       input logic [PW-1:0] rk, input logic rjr, input logic rkr);
        enq_valid           = 1'b1;
        enq_gen_op_type     = GENERAL_OPTYPE_3R;
        enq_spec_op_type    = spec;
        enq_rob_entry_index = rob;
        enq_preg_rd_index   = rd;
        enq_preg_rj_index   = rj;
        enq_preg_rk_index   = rk;
        enq_rj_ready        = rjr;
        enq_rk_ready        = rkr;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; FU_ready = 1'b0; enq_valid = 1'b0;
        enq_gen_op_type = '0; enq_spec_op_type = '0; enq_rob_entry_index = '0;
        enq_preg_rd_index = '0; enq_preg_rj_index = '0; enq_preg_rk_index = '0;
        enq_rj_ready = 1'b0; enq_rk_ready = 1'b0;
        wake_valid = '0; wake_preg_index = '0;

        // Reset state
        step();
        chk("rst_iq_valid", IQ_valid, 0);
        chk("rst_enq_ready", enq_ready, 1);
        chk("rst_count", entry_count, 0);
        chk("rst_rob", rob_entry_index, 0);
        chk("rst_rd", preg_rd_index, 0);
        rst = 1'b0;
        step();

        // Ready DIV enqueued, issued the following cycle
        FU_ready = 1'b1;
        enq(_3R_DIV, 5'd5, 6'd12, 6'd1, 6'd2, 1'b1, 1'b1);
        chk("t1_empty_iq_valid", IQ_valid, 0);
        step();
        enq_valid = 1'b0;
        chk("t1_iq_valid", IQ_valid, 1);
        chk("t1_rob", rob_entry_index, 5);
        chk("t1_rd", preg_rd_index, 12);
        chk("t1_gen", iss_gen_op_type, GENERAL_OPTYPE_3R);
        chk("t1_spec", iss_spec_op_type, _3R_DIV);
        chk("t1_count", entry_count, 1);
        step();
        chk("t1_count_after", entry_count, 0);
        chk("t1_iq_after", IQ_valid, 0);

        // Modulo op waits for rj=7, woken on port 1
        enq(_3R_MOD, 5'd6, 6'd13, 6'd7, 6'd8, 1'b0, 1'b1);
        step();
        enq_valid = 1'b0;
        chk("t2_not_ready", IQ_valid, 0);
        chk("t2_count", entry_count, 1);
        step();
        chk("t2_still_not_ready", IQ_valid, 0);
        wake_valid = 2'b10; wake_preg_index = {6'd7, 6'd3};
        chk("t2_wake_same_cycle", IQ_valid, 0);
        step();
        wake_valid = '0;
        chk("t2_woken", IQ_valid, 1);
        chk("t2_rob", rob_entry_index, 6);
        chk("t2_rj", preg_rj_index, 7);
        step();
        chk("t2_drained", entry_count, 0);

        // Fill to DEPTH with issue blocked
        FU_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            enq(_3R_DIVU, RW'(k), PW'(20 + k), 6'd1, 6'd2, 1'b1, 1'b1);
            step();
        end
        chk("t3_full_count", entry_count, 4);
        chk("t3_enq_ready", enq_ready, 0);
        chk("t3_head", rob_entry_index, 1);
        enq(_3R_DIVU, 5'd9, 6'd30, 6'd1, 6'd2, 1'b1, 1'b1);
        step();
        chk("t3_fifth_ignored", entry_count, 4);
        // Full queue refuses even while an issue fires
        FU_ready = 1'b1;
        chk("t3_iss1", rob_entry_index, 1);
        step();
        enq_valid = 1'b0;
        chk("t3_no_enq_on_full", entry_count, 3);
        chk("t3_iss2", rob_entry_index, 2);
        chk("t3_iss2_rd", preg_rd_index, 22);
        step();
        chk("t3_iss3", rob_entry_index, 3);
        step();
        chk("t3_iss4", rob_entry_index, 4);
        step();
        chk("t3_empty", entry_count, 0);
        chk("t3_empty_iq", IQ_valid, 0);

        // Younger ready entry bypasses older blocked one
        FU_ready = 1'b0;
        enq(_3R_MODU, 5'd1, 6'd40, 6'd10, 6'd2, 1'b0, 1'b1);
        step();
        enq(_3R_DIV, 5'd2, 6'd41, 6'd11, 6'd12, 1'b1, 1'b1);
        step();
        enq_valid = 1'b0;
        chk("t4_count", entry_count, 2);
        chk("t4_young_first", rob_entry_index, 2);
        // Issue rob 2 while enqueuing rob 3
        FU_ready = 1'b1;
        enq(_3R_MOD, 5'd3, 6'd42, 6'd1, 6'd2, 1'b1, 1'b1);
        step();
        enq_valid = 1'b0;
        chk("t4_count_enq_iss", entry_count, 2);
        chk("t4_next_rob", rob_entry_index, 3);
        step();
        chk("t4_old_blocked", IQ_valid, 0);
        chk("t4_count1", entry_count, 1);
        wake_valid = 2'b01; wake_preg_index = {6'd0, 6'd10};
        step();
        wake_valid = '0;
        chk("t4_old_woken", rob_entry_index, 1);
        chk("t4_old_spec", iss_spec_op_type, _3R_MODU);
        step();
        chk("t4_drained", entry_count, 0);

        // Same-cycle wakeup bypass into enqueue
        FU_ready = 1'b0;
        enq(_3R_DIV, 5'd7, 6'd43, 6'd9, 6'd4, 1'b0, 1'b1);
        wake_valid = 2'b01; wake_preg_index = {6'd0, 6'd9};
        step();
        wake_valid = '0; enq_valid = 1'b0;
        chk("t5_bypass", IQ_valid, 1);
        chk("t5_rob", rob_entry_index, 7);

        // rk wakeup with the same tag on both ports
        enq(_3R_DIV, 5'd14, 6'd44, 6'd1, 6'd30, 1'b1, 1'b0);
        step();
        enq(_3R_DIV, 5'd8, 6'd45, 6'd1, 6'd2, 1'b1, 1'b1);
        wake_valid = 2'b11; wake_preg_index = {6'd30, 6'd30};
        step();
        wake_valid = '0; enq_valid = 1'b0;
        chk("t6_count3", entry_count, 3);

        // Flush with a concurrent enqueue and issue
        flush = 1'b1; FU_ready = 1'b1;
        enq(_3R_DIV, 5'd11, 6'd46, 6'd1, 6'd2, 1'b1, 1'b1);
        chk("t6_flush_iq_current", IQ_valid, 1);
        step();
        flush = 1'b0; enq_valid = 1'b0;
        chk("t6_flush_count", entry_count, 0);
        chk("t6_flush_iq", IQ_valid, 0);

        // rk wake makes rob 14 issue ahead of nothing else
        FU_ready = 1'b0;
        enq(_3R_DIV, 5'd14, 6'd44, 6'd1, 6'd30, 1'b1, 1'b0);
        step();
        enq_valid = 1'b0;
        chk("t7_rk_wait", IQ_valid, 0);
        wake_valid = 2'b11; wake_preg_index = {6'd30, 6'd30};
        step();
        wake_valid = '0;
        chk("t7_rk_woken", rob_entry_index, 14);

        // Asynchronous reset mid-stream
        enq(_3R_DIV, 5'd15, 6'd47, 6'd1, 6'd2, 1'b1, 1'b1);
        step();
        enq_valid = 1'b0;
        chk("t8_pre_rst_count", entry_count, 2);
        rst = 1'b1;
        #1;
        chk("t8_rst_count", entry_count, 0);
        chk("t8_rst_iq", IQ_valid, 0);
        chk("t8_rst_enq_ready", enq_ready, 1);
        chk("t8_rst_rob", rob_entry_index, 0);
        #1;
        rst = 1'b0;
        step();
        FU_ready = 1'b1;
        enq(_3R_MODU, 5'd13, 6'd50, 6'd1, 6'd2, 1'b1, 1'b1);
        step();
        enq_valid = 1'b0;
        chk("t8_post_rst_rob", rob_entry_index, 13);
        step();
        chk("t8_post_rst_empty", entry_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
